// File: rtl/booth_radix4_seq_ctrl.sv
// ============================================================================
// Module      : booth_radix4_seq_ctrl
// Description : Sequential signed radix-4 Booth multiplier controller. It
//               processes one recoded digit per clock and pulses done when
//               the product is ready.
//               Optional feature macro: BOOTH_CLEAR_EN (adds the clear input).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_radix4_seq_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
`ifdef BOOTH_CLEAR_EN
    input  logic                 clear,
`endif
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    generate
        if ((WIDTH < 4) || ((WIDTH % 2) != 0)) begin : g_bad_width
            $error("booth_radix4_seq_ctrl: WIDTH must be even and >= 4");
        end
    endgenerate

    localparam int                 c_cnt_w = $clog2(WIDTH/2 + 1);
    localparam logic [c_cnt_w-1:0] c_steps = c_cnt_w'(WIDTH/2);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [WIDTH-1:0]       r_mreg;
    logic [WIDTH+1:0]       r_a;
    logic [WIDTH-1:0]       r_q;
    logic                   r_qm1;
    logic [c_cnt_w-1:0]     r_count;
    logic [2*WIDTH-1:0]     r_product;

    logic                   w_clear;
    logic                   w_accept;
    logic                   w_last_step;
    logic [WIDTH+1:0]       w_m_ext;
    logic [WIDTH+1:0]       w_m2;
    logic [WIDTH+1:0]       w_addend;
    logic [WIDTH+1:0]       w_sum;
    logic [WIDTH+1:0]       w_a_next;
    logic [WIDTH-1:0]       w_q_next;

`ifdef BOOTH_CLEAR_EN
    assign w_clear = clear;
`else
    assign w_clear = 1'b0;
`endif

    // Clear outranks start, so an accept never happens in a clearing cycle.
    assign w_accept    = start && !w_clear &&
                         ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_last_step = (r_count == c_one);

    assign busy    = (r_state == ST_RUN);
    assign done    = (r_state == ST_DONE);
    assign product = r_product;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_next = ST_RUN;
            ST_RUN:  if (w_last_step) w_state_next = ST_DONE;
            ST_DONE: w_state_next = w_accept ? ST_RUN : ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
        if (w_clear) begin
            w_state_next = ST_IDLE;
        end
    end

    // The accumulator is two bits wider than the operand so that +/-2M never overflows.
    assign w_m_ext = {{2{r_mreg[WIDTH-1]}}, r_mreg};
    assign w_m2    = {w_m_ext[WIDTH:0], 1'b0};

    always_comb begin
        w_addend = '0;
        case ({r_q[1:0], r_qm1})
            3'b001, 3'b010: w_addend = w_m_ext;
            3'b011:         w_addend = w_m2;
            3'b100:         w_addend = -w_m2;
            3'b101, 3'b110: w_addend = -w_m_ext;
            default:        w_addend = '0;
        endcase
    end

    assign w_sum    = r_a + w_addend;
    assign w_a_next = {{2{w_sum[WIDTH+1]}}, w_sum[WIDTH+1:2]};
    assign w_q_next = {w_sum[1:0], r_q[WIDTH-1:2]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mreg    <= '0;
            r_a       <= '0;
            r_q       <= '0;
            r_qm1     <= 1'b0;
            r_count   <= '0;
            r_product <= '0;
        end else if (w_clear) begin
            r_count <= '0;
        end else if (w_accept) begin
            r_mreg  <= multiplicand;
            r_a     <= '0;
            r_q     <= multiplier;
            r_qm1   <= 1'b0;
            r_count <= c_steps;
        end else if (r_state == ST_RUN) begin
            r_a     <= w_a_next;
            r_q     <= w_q_next;
            r_qm1   <= r_q[1];
            r_count <= r_count - c_one;
            if (w_last_step) begin
                r_product <= {w_a_next[WIDTH-1:0], w_q_next};
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_booth_radix4_seq_ctrl.sv
// ============================================================================
// Module      : tb_booth_radix4_seq_ctrl
// Description : Scoreboard bench for booth_radix4_seq_ctrl at WIDTH=4.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_booth_radix4_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] multiplicand = '0;
    logic [3:0] multiplier = '0;
    logic       busy;
    logic       done;
    logic [7:0] product;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    booth_radix4_seq_ctrl #(.WIDTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
`ifdef BOOTH_CLEAR_EN
        .clear        (clear),
`endif
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, want);
        end
    endtask

    // Pops one expected product for every done pulse the DUT presents.
    task automatic monitor_loop();
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (!rst && done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done got=%h expected=none", product);
                end else begin
                    e = exp_q.pop_front();
                    check("product", product, e);
                end
            end
        end
    endtask

    task automatic wait_done(input string name, input int want_cycles);
        int n = 0;
        bit seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n++;
            if (done) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout got=no_done expected=done", name);
        end else begin
            check({name, "_latency"}, 8'(n), 8'(want_cycles));
        end
    endtask

    task automatic do_mult(input logic [3:0] m, input logic [3:0] q, input logic [7:0] e);
        @(negedge clk);
        multiplicand = m;
        multiplier   = q;
        start        = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        start        = 1'b0;
        multiplicand = ~m;
        multiplier   = ~q;
        wait_done("mult", 2);
    endtask

    initial begin
        logic signed [3:0] ms;
        logic signed [3:0] qs;
        logic signed [7:0] ps;
        logic [3:0] bm [4];
        logic [3:0] bq [4];
        logic [7:0] be [4];

        fork
            monitor_loop();
            begin
                #1_000_000;
                $display("FAIL watchdog got=stalled expected=finish");
                $fatal(1, "watchdog expired");
            end
        join_none

        // Reset state
        @(negedge clk);
        check("reset_busy", 8'(busy), 8'h00);
        check("reset_done", 8'(done), 8'h00);
        check("reset_product", product, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        // Hand-computed vectors
        do_mult(4'd3, 4'd5, 8'h0F);
        do_mult(4'hD, 4'd5, 8'hF1);
        do_mult(4'd7, 4'h8, 8'hC8);
        do_mult(4'h8, 4'h8, 8'h40);
        do_mult(4'h8, 4'd7, 8'hC8);

        // Start during RUN is ignored; product holds the previous result
        @(negedge clk);
        multiplicand = 4'd3;
        multiplier   = 4'd5;
        start        = 1'b1;
        exp_q.push_back(8'h0F);
        @(negedge clk);
        check("run_busy", 8'(busy), 8'h01);
        check("hold_product", product, 8'hC8);
        multiplicand = 4'd7;
        multiplier   = 4'd7;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignore_start", 1);
        repeat (4) @(negedge clk);

        // Back-to-back with start held high
        bm = '{4'd2, 4'hF, 4'd6, 4'h9};
        bq = '{4'd7, 4'hF, 4'hB, 4'd3};
        be = '{8'h0E, 8'h01, 8'hE2, 8'hEB};
        @(negedge clk);
        multiplicand = bm[0];
        multiplier   = bq[0];
        start        = 1'b1;
        exp_q.push_back(be[0]);
        for (int i = 0; i < 4; i++) begin
            wait_done("b2b", 3);
            if (i < 3) begin
                multiplicand = bm[i+1];
                multiplier   = bq[i+1];
                exp_q.push_back(be[i+1]);
            end else begin
                start = 1'b0;
            end
        end
        repeat (3) @(negedge clk);

        // Asynchronous reset mid-RUN
        @(negedge clk);
        multiplicand = 4'd5;
        multiplier   = 4'd5;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("abort_busy", 8'(busy), 8'h00);
        check("abort_done", 8'(done), 8'h00);
        check("abort_product", product, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        do_mult(4'd2, 4'd3, 8'h06);

`ifdef BOOTH_CLEAR_EN
        do_mult(4'd3, 4'd5, 8'h0F);
        @(negedge clk);
        multiplicand = 4'd2;
        multiplier   = 4'd2;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clear_busy", 8'(busy), 8'h00);
        check("clear_done", 8'(done), 8'h00);
        check("clear_product", product, 8'h0F);
        repeat (4) @(negedge clk);
`endif

        // Exhaustive sweep against a signed model
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                ms = 4'(a);
                qs = 4'(b);
                ps = ms * qs;
                do_mult(4'(a), 4'(b), ps);
            end
        end

        repeat (4) @(negedge clk);
        check("pending_results", 8'(exp_q.size()), 8'h00);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
